// File: rtl/mux4x1_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 single-bit mux between four requesters, with a bounded hold time.
// Optional MUX_ARB_LOCK_EN adds a lock input that suppresses preemption and freezes the hold counter.
module mux4x1_rr_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       in_a,
    input  logic       in_b,
    input  logic       in_c,
    input  logic       in_d,
`ifdef MUX_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] gnt,
    output logic       Sel0,
    output logic       Sel1,
    output logic       busy,
    output logic       out_data,
    output logic       out_valid
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state;
    logic [1:0]       sel_q;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;

    logic [3:0] others;
    logic [2:0] pick_idle;
    logic [2:0] pick_next;
    logic       lock_on;
    logic       grant_en;
    logic [1:0] grant_idx;
    logic       drop;
    logic       mux_bit;

    // Returns {found, index} of the first set bit scanning start, start+1, ... mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign Sel1 = sel_q[1];
    assign Sel0 = sel_q[0];
    assign busy = |gnt;

    // The current owner is excluded so preemption always moves on; on release its bit is already clear.
    assign others    = req & ~gnt;
    assign pick_idle = rr_pick(req, ptr);
    assign pick_next = rr_pick(others, sel_q + 2'd1);

`ifdef MUX_ARB_LOCK_EN
    assign lock_on = lock && (state == OWN);
`else
    assign lock_on = 1'b0;
`endif

    always_comb begin
        grant_en  = 1'b0;
        grant_idx = 2'd0;
        drop      = 1'b0;
        if (state == IDLE) begin
            grant_en  = pick_idle[2];
            grant_idx = pick_idle[1:0];
        end else if (!req[sel_q]) begin
            grant_en  = pick_next[2];
            grant_idx = pick_next[1:0];
            drop      = !pick_next[2];
        end else if ((|others) && (cnt == CNT_LAST) && !lock_on) begin
            grant_en  = 1'b1;
            grant_idx = pick_next[1:0];
        end
    end

    always_comb begin
        case (sel_q)
            2'd0:    mux_bit = in_a;
            2'd1:    mux_bit = in_b;
            2'd2:    mux_bit = in_c;
            default: mux_bit = in_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            sel_q     <= 2'd0;
            ptr       <= 2'd0;
            cnt       <= '0;
            out_data  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_data  <= mux_bit;
            out_valid <= busy;
            if (grant_en) begin
                state <= OWN;
                gnt   <= 4'b0001 << grant_idx;
                sel_q <= grant_idx;
                ptr   <= grant_idx + 2'd1;
                cnt   <= '0;
            end else if (drop) begin
                state <= IDLE;
                gnt   <= 4'b0000;
                cnt   <= '0;
            end else if ((state == OWN) && !lock_on && (cnt != CNT_LAST)) begin
                // Saturates at the last value so a sole owner never wraps back to zero.
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
